mdr_mem_if: RTL
===============

# mdr_mem_if

Memory-interface stage sitting directly downstream of the system bus multiplexer. It holds the 16-bit memory address register (MAR) and the 8-bit memory data register (MDR), loads them from the bus word, and runs single-byte read or write cycles to external memory through a req/ack handshake. It reports busy, done and timeout status to the controller. It also returns read data toward the bus input for the MDR-to-bus transfer.

## Interface
- TIMEOUT, 15: max ACCESS cycles without memAck before aborting (1..15).
- CLK  in  1  system clock; all state changes on rising edge.
- nCLR  in  1  asynchronous, active-low reset.
- busIn  in  16  bus word (multiplexer output).
- Lmar  in  1  load MAR from busIn[15:0].
- Lmdr  in  1  load MDR from busIn[7:0]; effective only when iRDWR=1.
- Emdr  in  1  request MDR onto bus; effective only when iRDWR=0.
- iRDWR  in  1  cycle direction: 1 = write to memory, 0 = read from memory.
- start  in  1  one-cycle strobe beginning a memory cycle.
- memRData  in  8  memory read data, valid when memAck=1.
- memAck  in  1  memory completion.
- memAddr  out  16  address to memory (= MAR, continuous).
- memWData  out  8  write data (= MDR, continuous).
- memReq  out  1  access request.
- memWe  out  1  write enable (= memReq & latched direction).
- mdrOut  out  8  MDR contents toward bus input.
- mdrEn  out  1  = Emdr & ~iRDWR & ~busy.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  timeout flag, sticky until next accepted start.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: Lmar loads MAR; Lmdr&iRDWR loads MDR. start loads direction register op<=iRDWR, clears error and wait counter, and goes to ACCESS.
- Lmar, Lmdr and start in the same cycle: the registers load at that edge, so the access uses the new address/data.
- ACCESS: memReq=1 every cycle; memWe=op. memAck=1 → DONE; on read (op=0), MDR<=memRData at that edge. No ack → wait counter +1.
- Timeout: counter==TIMEOUT-1 with no ack → DONE, error<=1, MDR unchanged. Ack in that same cycle wins; it is a normal completion with no error.
- DONE: done=1, memReq=0, → IDLE next edge.
- While busy: Lmar, Lmdr and start are ignored; mdrEn=0.
- memAck outside ACCESS is ignored.
- Wait counter is 4 bits and saturates (never wraps).

## Timing
- Reset (nCLR=0, async): state IDLE, MAR=0, MDR=0, op=0, counter=0, error=0. Outputs: memReq=0, memWe=0, done=0, busy=0, memAddr=0, memWData=0, mdrOut=0. mdrEn follows its inputs.
- Reset mid-access drops memReq and memWe immediately; the aborted cycle reports no done.
- start sampled at edge 0 → memReq high from cycle 1.
- Zero-wait ack in cycle 1 → done=1 in cycle 2, IDLE in cycle 3.
- busy is high in cycles 1..2, so minimum start-to-start spacing is 3 cycles.
- N-cycle ack delay: done occurs in cycle N+2.
- Timeout: memReq is high for exactly TIMEOUT cycles; done and error rise together in the next cycle.
- Read data is visible on mdrOut in the same cycle done=1.

## Test plan
- Reset: hold nCLR=0 mid-ACCESS → memReq=0 at once, all registers 0, busy=0.
- Write: busIn=16'h2040 with Lmar; busIn=16'h00A5 with Lmdr, iRDWR=1; then start, ack in cycle 1 → memAddr=16'h2040, memWData=8'hA5, memWe=1 for one cycle, done in cycle 2, error=0.
- Read with 3 wait cycles: MAR=16'h00FF, iRDWR=0, start; memAck with memRData=8'h3C in the 4th ACCESS cycle → done in cycle 5. MDR=8'h3C; with Emdr=1 afterward, mdrEn=1 and mdrOut=8'h3C.
- Timeout: TIMEOUT=15, no ack → memReq high 15 cycles, then done=1 and error=1. MDR is unchanged. The next start clears error.
- Ack on the last allowed cycle (15th) → normal completion with error=0.
- Interference while busy: Lmar with busIn=16'h1234, a second start, and Emdr during ACCESS → MAR unchanged, no second access, mdrEn=0.

Source files
------------

// File: rtl/mdr_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : mdr_mem_if
// Purpose  : Memory-interface stage behind the system bus multiplexer. Holds
//            the 16-bit memory address register (MAR) and the 8-bit memory
//            data register (MDR), loads them from the bus word, and runs
//            single-byte read/write cycles to external memory through a
//            req/ack handshake with a bounded wait (timeout).
// Ports    : CLK, nCLR       clock, asynchronous active-low reset
//            busIn[15:0]     bus word from the multiplexer
//            Lmar, Lmdr      load MAR / MDR (MDR only when iRDWR=1)
//            Emdr            request MDR onto bus (only when iRDWR=0)
//            iRDWR           direction: 1 = write memory, 0 = read memory
//            start           one-cycle strobe beginning a memory cycle
//            memRData, memAck  memory read data / completion
//            memAddr, memWData, memReq, memWe   memory side outputs
//            mdrOut, mdrEn   MDR value and enable toward the bus input
//            busy, done, error  status to the controller
// Revision : 1.0 - initial release
// ============================================================================
module mdr_mem_if #(
    parameter int TIMEOUT = 15   // max ACCESS cycles without ack (1..15)
) (
    input  logic        CLK,
    input  logic        nCLR,
    input  logic [15:0] busIn,
    input  logic        Lmar,
    input  logic        Lmdr,
    input  logic        Emdr,
    input  logic        iRDWR,
    input  logic        start,
    input  logic [7:0]  memRData,
    input  logic        memAck,
    output logic [15:0] memAddr,
    output logic [7:0]  memWData,
    output logic        memReq,
    output logic        memWe,
    output logic [7:0]  mdrOut,
    output logic        mdrEn,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Wait-counter value at which an un-acked access is abandoned.
    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] mar;
    logic [7:0]  mdr;
    logic        op;        // latched direction of the current access
    logic [3:0]  wait_cnt;
    logic        err_flag;

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state    <= IDLE;
            mar      <= 16'h0000;
            mdr      <= 8'h00;
            op       <= 1'b0;
            wait_cnt <= 4'h0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Register loads and start share an edge, so a start in
                    // the same cycle as Lmar/Lmdr uses the new contents.
                    if (Lmar)
                        mar <= busIn;
                    if (Lmdr && iRDWR)
                        mdr <= busIn[7:0];
                    if (start) begin
                        op       <= iRDWR;
                        err_flag <= 1'b0;
                        wait_cnt <= 4'h0;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack on the final allowed cycle beats the timeout.
                    if (memAck) begin
                        if (!op)
                            mdr <= memRData;
                        state <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        err_flag <= 1'b1;
                        state    <= DONE;
                    end else if (wait_cnt != 4'hF) begin
                        wait_cnt <= wait_cnt + 4'h1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All status outputs decode directly from flops, so reset removes
    // memReq/memWe immediately without waiting for a clock edge.
    assign memAddr  = mar;
    assign memWData = mdr;
    assign mdrOut   = mdr;
    assign memReq   = (state == ACCESS);
    assign memWe    = (state == ACCESS) && op;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign error    = err_flag;
    assign mdrEn    = Emdr && !iRDWR && (state == IDLE);

endmodule
`default_nettype wire
